// File: rtl/imem_dmem_port_arbiter_if.sv
// Bundles the CPU-side fetch/data ports and the unified-memory request/ack bus
// that the arbiter sits between.
interface imem_dmem_port_arbiter_if;
  logic [31:0] pc_if;
  logic [31:0] inst_if;
  logic [31:0] dmem_addr_ma;
  logic [31:0] dmem_data_write_ma;
  logic [3:0]  dmem_read_ma;
  logic [2:0]  dmem_write_ma;
  logic [31:0] dmem_data_read_ma;
  logic        busywait;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  // The arbiter is the slave of the pipeline and drives the memory request side.
  modport slave (
    input  pc_if, dmem_addr_ma, dmem_data_write_ma, dmem_read_ma, dmem_write_ma,
    input  mem_rdata, mem_ack,
    output inst_if, dmem_data_read_ma, busywait,
    output mem_addr, mem_wdata, mem_rd, mem_wr, mem_funct3, err
  );

  modport master (
    output pc_if, dmem_addr_ma, dmem_data_write_ma, dmem_read_ma, dmem_write_ma,
    output mem_rdata, mem_ack,
    input  inst_if, dmem_data_read_ma, busywait,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, mem_funct3, err
  );
endinterface

// File: rtl/imem_dmem_port_arbiter.sv
// Time-multiplexes one single-ported unified memory between data access and
// instruction fetch, data first, stalling the pipeline until both complete.
module imem_dmem_port_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      rst_n,
  imem_dmem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, D_REQ, I_REQ, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg;
  logic [7:0]  cnt_reg;
  logic [31:0] inst_reg;
  logic [31:0] dread_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic        mem_rd_reg;
  logic        mem_wr_reg;
  logic [2:0]  mem_funct3_reg;
  logic        err_reg;

  logic timed_out;
  logic complete;

  // An ack on the timeout edge counts as a normal completion.
  assign timed_out = (cnt_reg == CNT_LAST) && !bus.mem_ack;
  assign complete  = bus.mem_ack || timed_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      inst_reg       <= NOP_INST;
      dread_reg      <= '0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_rd_reg     <= 1'b0;
      mem_wr_reg     <= 1'b0;
      mem_funct3_reg <= '0;
      err_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (bus.dmem_write_ma[2]) begin
            state_reg      <= D_REQ;
            mem_wr_reg     <= 1'b1;
            mem_rd_reg     <= 1'b0;
            mem_addr_reg   <= bus.dmem_addr_ma;
            mem_wdata_reg  <= bus.dmem_data_write_ma;
            mem_funct3_reg <= {1'b0, bus.dmem_write_ma[1:0]};
          end else if (bus.dmem_read_ma[3]) begin
            state_reg      <= D_REQ;
            mem_rd_reg     <= 1'b1;
            mem_wr_reg     <= 1'b0;
            mem_addr_reg   <= bus.dmem_addr_ma;
            mem_funct3_reg <= bus.dmem_read_ma[2:0];
          end else begin
            state_reg      <= I_REQ;
            mem_rd_reg     <= 1'b1;
            mem_wr_reg     <= 1'b0;
            mem_addr_reg   <= bus.pc_if;
            mem_funct3_reg <= 3'b010;
          end
        end
        D_REQ: begin
          if (complete) begin
            // mem_rd_reg still marks whether this data access was a load.
            if (mem_rd_reg) begin
              dread_reg <= bus.mem_ack ? bus.mem_rdata : 32'h0;
            end
            if (timed_out) begin
              err_reg <= 1'b1;
            end
            state_reg      <= I_REQ;
            cnt_reg        <= '0;
            mem_rd_reg     <= 1'b1;
            mem_wr_reg     <= 1'b0;
            mem_addr_reg   <= bus.pc_if;
            mem_funct3_reg <= 3'b010;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        I_REQ: begin
          if (complete) begin
            inst_reg <= bus.mem_ack ? bus.mem_rdata : NOP_INST;
            if (timed_out) begin
              err_reg <= 1'b1;
            end
            mem_rd_reg <= 1'b0;
            state_reg  <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busywait          = (state_reg != DONE);
  assign bus.inst_if           = inst_reg;
  assign bus.dmem_data_read_ma = dread_reg;
  assign bus.mem_addr          = mem_addr_reg;
  assign bus.mem_wdata         = mem_wdata_reg;
  assign bus.mem_rd            = mem_rd_reg;
  assign bus.mem_wr            = mem_wr_reg;
  assign bus.mem_funct3        = mem_funct3_reg;
  assign bus.err               = err_reg;

endmodule
